// File: rtl/cic_comp_fir.sv
// cic_comp_fir: post-CIC droop-compensation FIR, 8-tap symmetric, one shared MAC.
// Optional build macro COMP_FIR_DEC2_EN: decimate the output by 2 (odd-phase
// samples only shift the delay line and never start a MAC pass).
module cic_comp_fir #(
   parameter int unsigned DATA_W = 24,
   parameter int unsigned COEF_W = 9,
   parameter int unsigned ACC_W  = 36   // at least DATA_W+COEF_W+3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [DATA_W-1:0] din,
   input  logic                     din_valid,
   output logic signed [DATA_W-1:0] dout,
   output logic                     dout_valid,
   output logic                     busy,
   output logic                     overrun
);

   localparam int unsigned TAPS  = 8;
   localparam int unsigned TAP_W = 3;
   localparam int unsigned SHIFT = 8;

   // Rounding offset of half an output LSB, and the output clamp limits.
   localparam logic signed [ACC_W-1:0] RND     = ACC_W'(128);
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_OUT  = 2'd2
   } state_e;

   state_e                    state_q, state_d;
   logic signed [DATA_W-1:0]  x_q [TAPS];
   logic signed [DATA_W-1:0]  x_d [TAPS];
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic [TAP_W-1:0]          tap_q, tap_d;
   logic signed [DATA_W-1:0]  dout_q, dout_d;
   logic                      dout_valid_q, dout_valid_d;
   logic                      busy_q, busy_d;
   logic                      overrun_q, overrun_d;
`ifdef COMP_FIR_DEC2_EN
   logic                      phase_q, phase_d;
`endif

   logic signed [ACC_W-1:0]   mac_term;
   logic signed [ACC_W-1:0]   rnd_sum;
   logic signed [ACC_W-1:0]   shifted;

   // Hard-coded symmetric compensation taps (DC gain 256).
   function automatic logic signed [COEF_W-1:0] coef(input logic [TAP_W-1:0] k);
      case (k)
         3'd0, 3'd7: coef = COEF_W'(-1);
         3'd1, 3'd6: coef = COEF_W'(3);
         3'd2, 3'd5: coef = COEF_W'(-12);
         default:    coef = COEF_W'(138);
      endcase
   endfunction

   // Datapath: one product per clk, then round-half-up and floor-shift by 8.
   always_comb begin
      mac_term = ACC_W'(x_q[tap_q]) * ACC_W'(coef(tap_q));
      rnd_sum  = acc_q + RND;
      shifted  = rnd_sum >>> SHIFT;
   end

   // Next-state and output logic for the IDLE -> MAC -> OUT pass.
   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      acc_d        = acc_q;
      tap_d        = tap_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      busy_d       = busy_q;
      overrun_d    = overrun_q;
`ifdef COMP_FIR_DEC2_EN
      phase_d      = phase_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (din_valid) begin
               x_d[0] = din;
               for (int i = 1; i < TAPS; i++) begin
                  x_d[i] = x_q[i-1];
               end
`ifdef COMP_FIR_DEC2_EN
               phase_d = ~phase_q;
               if (!phase_q) begin
                  acc_d   = '0;
                  tap_d   = '0;
                  busy_d  = 1'b1;
                  state_d = ST_MAC;
               end
`else
               acc_d   = '0;
               tap_d   = '0;
               busy_d  = 1'b1;
               state_d = ST_MAC;
`endif
            end
         end
         ST_MAC: begin
            if (din_valid) begin
               overrun_d = 1'b1;
            end
            acc_d = acc_q + mac_term;
            tap_d = tap_q + TAP_W'(1);
            if (tap_q == TAP_W'(TAPS - 1)) begin
               state_d = ST_OUT;
            end
         end
         ST_OUT: begin
            if (din_valid) begin
               overrun_d = 1'b1;
            end
            if (shifted > SAT_MAX) begin
               dout_d = DATA_W'(SAT_MAX);
            end else if (shifted < SAT_MIN) begin
               dout_d = DATA_W'(SAT_MIN);
            end else begin
               dout_d = DATA_W'(shifted);
            end
            dout_valid_d = 1'b1;
            busy_d       = 1'b0;
            state_d      = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State register; synchronous reset discards any in-flight pass.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         x_q          <= '{default: '0};
         acc_q        <= '0;
         tap_q        <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef COMP_FIR_DEC2_EN
         phase_q      <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         acc_q        <= acc_d;
         tap_q        <= tap_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         busy_q       <= busy_d;
         overrun_q    <= overrun_d;
`ifdef COMP_FIR_DEC2_EN
         phase_q      <= phase_d;
`endif
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign busy       = busy_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Self-checking bench for cic_comp_fir against an arithmetic FIR model.
module tb_cic_comp_fir;

   localparam int unsigned DW = 24;

   logic                 clk;
   logic                 rst;
   logic signed [DW-1:0] din;
   logic                 din_valid;
   logic signed [DW-1:0] dout;
   logic                 dout_valid;
   logic                 busy;
   logic                 overrun;

   int n_checks;
   int n_fail;

   // Reference model: sample history (index 0 newest) and output phase.
   longint hist [8];
   longint coefs [8] = '{-1, 3, -12, 138, 138, -12, 3, -1};
   bit     phase;

   cic_comp_fir dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .din_valid  (din_valid),
      .dout       (dout),
      .dout_valid (dout_valid),
      .busy       (busy),
      .overrun    (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      assert (got === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint model_out();
      longint s;
      longint r;
      s = 0;
      for (int k = 0; k < 8; k++) s += coefs[k] * hist[k];
      r = (s + 128) >>> 8;
      if (r > 8388607) r = 8388607;
      if (r < -8388608) r = -8388608;
      return r;
   endfunction

   function automatic bit model_accept(input longint v);
      bit runs;
      for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = v;
`ifdef COMP_FIR_DEC2_EN
      runs  = !phase;
      phase = !phase;
`else
      runs  = 1'b1;
`endif
      return runs;
   endfunction

   function automatic longint sdout();
      return longint'(dout);
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      din_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      for (int k = 0; k < 8; k++) hist[k] = 0;
      phase = 1'b0;
   endtask

   // Feed one accepted sample, check the full pass timing, consume `gap` clks.
   task automatic send(input longint v, input int gap, input string tag);
      bit     runs;
      longint exp;
      din       = DW'(v);
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      runs = model_accept(v);
      exp  = model_out();
      if (runs) begin
         check({tag, "_busy"}, longint'(busy), 1);
         for (int i = 1; i <= 8; i++) begin
            tick();
            check({tag, "_early_valid"}, longint'(dout_valid), 0);
         end
         tick();
         check({tag, "_valid"}, longint'(dout_valid), 1);
         check({tag, "_dout"}, sdout(), exp);
         tick();
         check({tag, "_valid_pulse"}, longint'(dout_valid), 0);
         check({tag, "_idle"}, longint'(busy), 0);
      end else begin
         check({tag, "_skip_busy"}, longint'(busy), 0);
         for (int i = 1; i <= 10; i++) begin
            tick();
            check({tag, "_skip_valid"}, longint'(dout_valid), 0);
         end
      end
      for (int i = 11; i < gap; i++) tick();
   endtask

   initial begin
      logic [DW-1:0] r;
      longint        first_exp;
      longint        held;
      longint        sat_pat [8] = '{-8388607, 8388607, -8388607, 8388607,
                                     8388607, -8388607, 8388607, -8388607};
      n_checks  = 0;
      n_fail    = 0;
      din       = '0;
      din_valid = 1'b0;
      rst       = 1'b0;

      // Reset state.
      do_reset();
      check("rst_dout", sdout(), 0);
      check("rst_valid", longint'(dout_valid), 0);
      check("rst_busy", longint'(busy), 0);
      check("rst_overrun", longint'(overrun), 0);

      // Impulse response.
      send(1000, 64, "imp0");
      for (int i = 0; i < 8; i++) send(0, 64, "imp");

      // DC step at 256 and at full scale.
      do_reset();
      for (int i = 0; i < 10; i++) send(256, 64, "dc256");
      check("dc256_final", sdout(), 256);
      do_reset();
      for (int i = 0; i < 10; i++) send(8388607, 64, "dcmax");
      check("dcmax_final", sdout(), 8388607);

      // Saturation in both directions.
      do_reset();
      for (int i = 7; i >= 0; i--) send(sat_pat[i], 12, "satp");
`ifndef COMP_FIR_DEC2_EN
      check("sat_pos", sdout(), 8388607);
`endif
      for (int i = 7; i >= 0; i--) send(-sat_pat[i], 12, "satn");
`ifndef COMP_FIR_DEC2_EN
      check("sat_neg", sdout(), -8388608);
`endif

      // Random samples and spacings.
      do_reset();
      for (int i = 0; i < 30; i++) begin
         r = DW'($urandom);
         send(longint'($signed(r)), int'($urandom_range(12, 70)), "rand");
      end

      // Overrun: second pulse 3 clks later is dropped.
      do_reset();
      din = DW'(5000);
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      void'(model_accept(5000));
      first_exp = model_out();
      tick();
      tick();
      din = DW'(-77777);
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      check("ovr_set", longint'(overrun), 1);
      for (int i = 4; i <= 8; i++) begin
         tick();
         check("ovr_early_valid", longint'(dout_valid), 0);
      end
      tick();
      check("ovr_valid", longint'(dout_valid), 1);
      check("ovr_dout", sdout(), first_exp);
      for (int i = 0; i < 50; i++) begin
         tick();
         check("ovr_single_valid", longint'(dout_valid), 0);
      end
      send(3000, 64, "ovr_next");
      check("ovr_held", longint'(overrun), 1);

      // Reset during MAC cycle 4 discards the pass.
      send(123456, 64, "pre_rst");
      din = DW'(4000);
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 8; k++) hist[k] = 0;
      phase = 1'b0;
      check("mrst_busy", longint'(busy), 0);
      check("mrst_dout", sdout(), 0);
      check("mrst_valid", longint'(dout_valid), 0);
      check("mrst_overrun", longint'(overrun), 0);
      for (int i = 0; i < 12; i++) begin
         tick();
         check("mrst_no_valid", longint'(dout_valid), 0);
      end

      // din_valid coincident with rst is ignored.
      din = DW'(999999);
      din_valid = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      din_valid = 1'b0;
      check("rstvalid_busy", longint'(busy), 0);
      tick();
      check("rstvalid_busy2", longint'(busy), 0);

      // Impulse again after the mid-pass reset; dout holds between strobes.
      send(1000, 64, "imp2_0");
      for (int i = 0; i < 8; i++) send(0, 64, "imp2");
      held = sdout();
      for (int i = 0; i < 20; i++) tick();
      check("dout_hold", sdout(), held);
      check("dout_hold_model", sdout(), model_out());

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
